// File: rtl/quad_step_decoder.sv
// Quadrature (A/B) front end: two-flop synchronisers, per-channel glitch filters and an edge decoder.
// It produces a one-cycle step pulse and a held direction. Define QDEC_X1_MODE_EN for x1 decoding; the default is x4.
module quad_step_decoder #(
  parameter int FILT_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             enable,
  input  logic             clear_err,
  output logic             step,
  output logic             up_down,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CNT_W  = 4;
  localparam int SET_W  = 5;
  localparam int SETTLE = FILT_LEN + 3;

  typedef enum logic {INIT, TRACK} state_t;

  state_t             state, state_next;
  logic               track;
  logic [SET_W-1:0]   settle_cnt;
  logic               settle_done;
  logic [1:0]         sync_meta, sync_s;
  logic [1:0]         filt, ab_prev;
  logic [CNT_W-1:0]   filt_cnt [2];
  logic [1:0]         diff;
  logic               step_ok, dir_up, dbl;
  logic               step_event, err_event;

  // Bit 1 carries channel A and bit 0 carries channel B throughout.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= {a_in, b_in};
      sync_s    <= sync_meta;
    end
  end

  // A channel must disagree with its filtered value for FILT_LEN consecutive samples before the filtered value follows it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt        <= '0;
      filt_cnt[0] <= '0;
      filt_cnt[1] <= '0;
    end else if (!track) begin
      filt        <= sync_s;
      filt_cnt[0] <= '0;
      filt_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_s[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == CNT_W'(FILT_LEN - 1)) begin
          filt[i]     <= sync_s[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ab_prev tracks sync during INIT so the first TRACK cycle sees no spurious edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ab_prev <= '0;
    else if (!track) ab_prev <= sync_s;
    else             ab_prev <= filt;
  end

  assign settle_done = (settle_cnt == SET_W'(SETTLE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     settle_cnt <= '0;
    else if (!track && !settle_done) settle_cnt <= settle_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_next;
  end

  // NOTE: each always_comb assigns a default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (settle_done) state_next = TRACK;
      TRACK:   state_next = TRACK;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    track = (state == TRACK);
  end

  always_comb begin
    diff   = filt ^ ab_prev;
    dbl    = &diff;
    dir_up = ab_prev[0] ^ filt[1];
`ifdef QDEC_X1_MODE_EN
    step_ok = (^diff) && (((ab_prev == 2'b10) && (filt == 2'b11)) ||
                          ((ab_prev == 2'b11) && (filt == 2'b10)));
`else
    step_ok = ^diff;
`endif
    step_event = track && enable && step_ok;
    err_event  = track && enable && dbl;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step    <= 1'b0;
      err     <= 1'b0;
      up_down <= 1'b1;
      err_cnt <= '0;
    end else begin
      step <= step_event;
      err  <= err_event;
      if (step_event) up_down <= dir_up;
      if (clear_err)                       err_cnt <= err_event ? ERR_W'(1) : '0;
      else if (err_event && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: a table of quadrature vectors plus hand sequences.
// The hand sequences cover reset, glitch rejection, error saturation and clear_err.
module tb_quad_step_decoder;

`ifdef QDEC_X1_MODE_EN
  localparam bit X1 = 1'b1;
`else
  localparam bit X1 = 1'b0;
`endif
  localparam int LAT = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_in = 1'b1, b_in = 1'b1;
  logic       enable = 1'b1, clear_err = 1'b0;
  logic       step, up_down, err;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0] ab;
    logic       en;
    int         steps;
    logic       ud;
  } vec_t;

  vec_t vecs [13];

  quad_step_decoder #(.FILT_LEN(3), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .enable(enable), .clear_err(clear_err),
    .step(step), .up_down(up_down), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, actual, expected);
  endtask

  task automatic drive_ab(input logic [1:0] v, input logic en);
    @(posedge clk);
    #1;
    a_in   = v[1];
    b_in   = v[0];
    enable = en;
  endtask

  // Runs n cycles and samples at each falling edge. first is the index (1..n) of the first rising edge followed by step.
  task automatic hold(input int n, output int steps, output int errs, output int first);
    steps = 0; errs = 0; first = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (step === 1'b1) begin
        steps++;
        if (first == 0) first = i;
      end
      if (err === 1'b1) errs++;
    end
  endtask

  initial begin
    int s, e, f, tot_s, tot_e;
    logic ud_exp;

    vecs[0]  = '{2'b10, 1'b1, X1 ? 0 : 1, 1'b1};
    vecs[1]  = '{2'b11, 1'b1, 1,          1'b1};
    vecs[2]  = '{2'b01, 1'b1, X1 ? 0 : 1, 1'b1};
    vecs[3]  = '{2'b00, 1'b1, X1 ? 0 : 1, 1'b1};
    vecs[4]  = '{2'b01, 1'b1, X1 ? 0 : 1, X1 ? 1'b1 : 1'b0};
    vecs[5]  = '{2'b11, 1'b1, X1 ? 0 : 1, X1 ? 1'b1 : 1'b0};
    vecs[6]  = '{2'b10, 1'b1, 1,          1'b0};
    vecs[7]  = '{2'b00, 1'b1, X1 ? 0 : 1, 1'b0};
    vecs[8]  = '{2'b10, 1'b0, 0,          1'b0};
    vecs[9]  = '{2'b11, 1'b0, 0,          1'b0};
    vecs[10] = '{2'b01, 1'b0, 0,          1'b0};
    vecs[11] = '{2'b01, 1'b1, 0,          1'b0};
    vecs[12] = '{2'b00, 1'b1, X1 ? 0 : 1, X1 ? 1'b0 : 1'b1};

    // Reset with both inputs high; outputs must hold reset values while reset is asserted and after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_step", step, 0);
    check("rst_err", err, 0);
    check("rst_up_down", up_down, 1);
    check("rst_err_cnt", err_cnt, 0);
    reset = 1'b1;
    hold(10, s, e, f);
    check("post_rst_steps", s, 0);
    check("post_rst_errs", e, 0);
    check("post_rst_up_down", up_down, 1);
    check("post_rst_err_cnt", err_cnt, 0);

    // Reset again from 00 so the table starts from a known filtered state.
    @(negedge clk);
    reset = 1'b0; a_in = 1'b0; b_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hold(10, s, e, f);
    check("init00_steps", s, 0);

    for (int i = 0; i < 13; i++) begin
      drive_ab(vecs[i].ab, vecs[i].en);
      hold(10, s, e, f);
      check($sformatf("vec%0d_steps", i), s, vecs[i].steps);
      check($sformatf("vec%0d_errs", i), e, 0);
      check($sformatf("vec%0d_up_down", i), up_down, vecs[i].ud);
      if (vecs[i].steps > 0) check($sformatf("vec%0d_latency", i), f, LAT);
    end
    ud_exp = X1 ? 1'b0 : 1'b1;

    // A two-cycle glitch on A must be rejected by the filter.
    @(posedge clk); #1; a_in = 1'b1;
    repeat (2) @(posedge clk);
    #1; a_in = 1'b0;
    hold(10, s, e, f);
    check("glitch_steps", s, 0);
    check("glitch_errs", e, 0);
    check("glitch_filt", dut.filt, 0);

    // Repeated double transitions 00<->11: every one is an error, and the counter saturates.
    tot_s = 0; tot_e = 0;
    for (int i = 0; i < 300; i++) begin
      drive_ab(2'b11, 1'b1);
      hold(8, s, e, f); tot_s += s; tot_e += e;
      drive_ab(2'b00, 1'b1);
      hold(8, s, e, f); tot_s += s; tot_e += e;
      if (i == 0) check("err_cnt_first_pair", err_cnt, 2);
    end
    check("dbl_err_pulses", tot_e, 600);
    check("dbl_steps", tot_s, 0);
    check("err_cnt_sat", err_cnt, 255);
    check("dbl_up_down", up_down, ud_exp);

    @(posedge clk); #1; clear_err = 1'b1;
    @(posedge clk); #1; clear_err = 1'b0;
    @(negedge clk);
    check("clear_err_cnt", err_cnt, 0);

    // clear_err on the same edge as an error event: the count must become 1.
    drive_ab(2'b11, 1'b1);
    hold(8, s, e, f);
    check("one_err_cnt", err_cnt, 1);
    drive_ab(2'b00, 1'b1);
    repeat (LAT - 1) @(posedge clk);
    #1; clear_err = 1'b1;
    @(posedge clk);
    #1; clear_err = 1'b0;
    @(negedge clk);
    check("clr_with_err_pulse", err, 1);
    check("clr_with_err_cnt", err_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream control stage for the 4-bit up/down counter.
- Converts two asynchronous quadrature inputs (A/B) into a one-cycle count-enable pulse `step` and a held direction `up_down`.
- Both outputs feed the counter's enable and `up_down` inputs directly.
- Includes input synchronisation, per-channel glitch filtering, illegal-transition detection and a saturating error counter.

Parameters:
- FILT_LEN, 3, consecutive stable samples a synchronised input must hold before the filtered value updates (legal range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_in  input  1  quadrature channel A, asynchronous to clk.
- b_in  input  1  quadrature channel B, asynchronous to clk.
- enable  input  1  when 0, `step` and `err` are suppressed; tracking continues.
- clear_err  input  1  synchronous clear of `err_cnt`.
- step  output  1  one-cycle pulse per accepted quadrature edge.
- up_down  output  1  direction of the last accepted edge: 1 = up, 0 = down.
- err  output  1  one-cycle pulse on an illegal double transition.
- err_cnt  output  ERR_W  saturating count of illegal transitions.

Behaviour:
- Reset (reset=0, asynchronous):
  - step=0, err=0, up_down=1, err_cnt=0.
  - Sync flops, filter counters and filtered state go to 0; FSM goes to INIT.
- Synchroniser: 2-flop chain per channel (a_s, b_s).
- Filter, per channel:
  - Counter increments while the sync value differs from the filtered value.
  - Counter clears when the sync value equals the filtered value, so glitches shorter than FILT_LEN are rejected.
  - When the counter reaches FILT_LEN, the filtered value takes the sync value and the counter clears.
- FSM states INIT, TRACK:
  - INIT: filtered {A,B} loads the sync values directly every cycle with no filtering. A settle counter runs 2+FILT_LEN+1 cycles, then the FSM moves to TRACK. step and err stay 0 in INIT.
  - TRACK: normal decode. reset is the only path back to INIT.
- Decode on a change of filtered {A,B} in TRACK:
  - Up sequence: 00→10→11→01→00.
  - Down sequence: the reverse.
  - Single-bit change: step=1 for one cycle. up_down is updated in the same cycle as step and holds until the next accepted edge.
  - Both bits change in the same cycle: err=1 for one cycle, no step, up_down unchanged. err_cnt increments and saturates at 2^ERR_W−1.
- Latency: an input change that is stable from rising edge k produces step high after edge k+2+FILT_LEN+1. With FILT_LEN=3 that is the 6th edge.
- enable=0:
  - Filtered state and FSM still track.
  - step and err are forced to 0; up_down and err_cnt do not update.
  - No burst of steps on re-enable.
- clear_err:
  - Clears err_cnt next edge.
  - Simultaneous with an err event: err_cnt becomes 1.
- No edges, or an edge that returns to the same filtered state: no output activity.

Optional Feature:
- Macro: QDEC_X1_MODE_EN.
- Defined: x1 decoding. step asserts only on transition 10→11 (up) or 11→10 (down). Other legal transitions update the state silently. Double transitions still raise err.
- Undefined: x4 decoding. Every legal transition produces step.

Test Plan:
- Reset with a_in=b_in=1, release, wait 10 cycles → no step, no err; up_down=1, err_cnt=0.
- From 00, drive 4 up transitions {A,B}=10,11,01,00, each held 10 cycles → exactly 4 step pulses, each at edge 6 after its change, with up_down=1. With QDEC_X1_MODE_EN → 1 step.
- Drive the down sequence 01,11,10,00 → 4 steps with up_down=0; up_down remains 0 afterwards.
- Pulse a_in high for 2 cycles (FILT_LEN=3) → no step, filtered state unchanged.
- Switch 00→11 in one cycle, repeated 300 times, with the return to 00 also a double change → err pulses every time; err_cnt saturates at 255. Then clear_err=1 for one cycle → err_cnt=0.
- enable=0 during 3 up transitions, then enable=1 → no step during or after the disable window; the next transition yields exactly one step.
